ram_sp_pipe: RTL
================

// Module: ram_sp_pipe
// PURPOSE
// - Parametrised single-port synchronous RAM: width, depth, byte-write enables and read latency are all configurable.
// - Adds a valid/ready request interface, a pipelined read response and a hardware clear sequence after reset.
// - Used as the general data/scratch store behind the CPU datapath and its test benches.
// PARAMETERS
// - DATA_W        16   data width in bits; must be a multiple of 8.
// - ADDR_W        8    address width in bits.
// - DEPTH         256  number of words; 1..2**ADDR_W.
// - RD_LAT        1    read latency in cycles from request accept to rsp_valid; 1..4.
// - CLEAR_ON_RST  1    1 = zero every word after reset; 0 = contents undefined, ready right after reset.
// PORTS
// - clk        in   1            single clock; all logic samples on posedge.
// - rst        in   1            synchronous, active-low reset.
// - req_valid  in   1            request present.
// - req_ready  out  1            block accepts a request this cycle.
// - req_we     in   1            1 = write, 0 = read.
// - req_be     in   DATA_W/8     byte enables for writes; bit i covers data[8i+7:8i].
// - req_addr   in   ADDR_W       word address.
// - req_wdata  in   DATA_W       write data.
// - rsp_valid  out  1            read data valid; 1-cycle pulse per read.
// - rsp_rdata  out  DATA_W       read data; 0 whenever rsp_valid=0.
// - rsp_err    out  1            qualifies rsp_valid: read address was >= DEPTH.
// - init_done  out  1            clear sequence finished; stays 1 until next reset.
// BEHAVIOUR
// - Reset (rst=0 at posedge): all outputs 0; read pipeline flushed; clear counter=0.
// - Reset takes effect mid-operation: in-flight reads are discarded with no rsp_valid, and the clear restarts at word 0.
// - FSM states:
//   - S_CLEAR: one word zeroed per cycle at clr_addr=0..DEPTH-1; req_ready=0.
//     After word DEPTH-1 -> S_RUN, and init_done=1 from the next cycle.
//     Clear takes exactly DEPTH cycles.
//   - S_RUN: req_ready=1 every cycle; there is no response backpressure.
//   - Reset exit goes to S_CLEAR if CLEAR_ON_RST=1, else to S_RUN with init_done=1 on the first cycle out of reset.
// - Accept: req_valid & req_ready at a posedge; exactly one operation per cycle.
// - Write: each byte with req_be[i]=1 is updated at the accepting edge; other bytes keep their value.
//   - be=0 is a legal no-op.
//   - Writes produce no response.
//   - addr >= DEPTH: the write is dropped silently and memory is untouched.
// - Read: the read accepted at edge N gives rsp_valid=1 for the cycle after edge N+RD_LAT-1.
//   - RD_LAT=1 means data appears in the cycle right after the accept.
//   - Responses come back in order, and a read can be accepted every cycle (full throughput).
//   - addr >= DEPTH: rsp_rdata=0 and rsp_err=1, with the same latency.
// - Ordering: a read accepted the cycle after a write to the same address returns the new data (no stale forwarding hazard).
// - Array contents are not reset by rst unless CLEAR_ON_RST=1.
// - Requests presented while req_ready=0 are ignored; the requester must hold them.
// STRUCTURE
// - Package ram_pkg: state localparams S_CLEAR and S_RUN, the RD_LAT_MAX=4 constant, and a function be_merge(old, new, be).
// - Sub-module ram_rd_delay (RD_LAT-1 register stages carrying valid/data/err, flushed by rst) for read latencies above 1.
//   The array read register supplies the first stage.
// - Top module holds the memory array, the FSM, the clear counter and the accept/address-range logic.
// TESTING
// - CLEAR_ON_RST=1, DEPTH=256: release rst.
//   -> req_ready=0 for 256 cycles, then init_done=1.
//   -> Reading every address returns 16'h0000.
// - Write 0xA5A5 to addr 8'h10 with be=2'b11, then write 0x3C3C with be=2'b01, then read.
//   -> rsp_rdata=16'hA53C after exactly RD_LAT cycles.
// - RD_LAT=3: issue back-to-back reads of addr 0..7, pre-written with value = addr.
//   -> Eight consecutive rsp_valid pulses carrying 0..7, the first arriving 3 cycles after the first accept.
// - DEPTH=200, ADDR_W=8: write addr 250, then read addr 250.
//   -> rsp_valid=1, rsp_err=1, rsp_rdata=0, and no write lands at any in-range address.
// - Assert rst=0 while two reads are in flight and during S_CLEAR at word 100.
//   -> No rsp_valid is produced; after release the clear restarts at word 0 and again takes DEPTH cycles.
// - CLEAR_ON_RST=0.
//   -> req_ready=1 and init_done=1 on the first cycle after reset; a write followed by a read of the same address returns the written data.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the pipelined single-port RAM: FSM state codes,
// latency limit and the byte-enable merge helper.
package ram_pkg;

    typedef logic state_t;

    localparam state_t S_CLEAR = 1'b0;
    localparam state_t S_RUN   = 1'b1;

    localparam int RD_LAT_MAX = 4;

    // Widest word the merge helper handles; callers zero-extend narrower words.
    localparam int DATA_W_MAX = 64;
    localparam int BE_W_MAX   = DATA_W_MAX / 8;

    // Replace each byte of old_w whose enable bit is set with the same byte of new_w.
    function automatic logic [DATA_W_MAX-1:0] be_merge(
        input logic [DATA_W_MAX-1:0] old_w,
        input logic [DATA_W_MAX-1:0] new_w,
        input logic [BE_W_MAX-1:0]   be
    );
        logic [DATA_W_MAX-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W_MAX; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_delay.sv
// Extra read-response register stages (valid/data/err) used when the read
// latency exceeds one cycle. STAGES=0 is a straight pass-through.
module ram_rd_delay #(
    parameter int DATA_W = 16,
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign out_err   = in_err;
        end else begin : g_pipe
            logic [STAGES-1:0] v_q;
            logic [STAGES-1:0] e_q;
            logic [DATA_W-1:0] d_q [STAGES];

            // Shift the response down the pipe; reset flushes every in-flight read.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_q <= '0;
                    e_q <= '0;
                    for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
                end else begin
                    v_q[0] <= in_valid;
                    e_q[0] <= in_err;
                    d_q[0] <= in_data;
                    for (int i = 1; i < STAGES; i++) begin
                        v_q[i] <= v_q[i-1];
                        e_q[i] <= e_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end

            assign out_valid = v_q[STAGES-1];
            assign out_data  = d_q[STAGES-1];
            assign out_err   = e_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_sp_pipe.sv
// Single-port synchronous RAM with valid/ready requests, byte-enable writes,
// a pipelined in-order read response and an optional post-reset clear.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_CLEAR | zeroing one word per cycle at clr_addr; requests not accepted
// S_RUN   | accepting one request per cycle; init_done high
//
// req_ready/init_done are gated by rst so they read 0 while reset is held and
// rise on the first cycle rst is released when no clear is configured.
module ram_sp_pipe
    import ram_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
    localparam int STAGES = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX - 1 :
                            (RD_LAT < 1)          ? 0 : RD_LAT - 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              clr_last;
    logic              clr_we;
    logic              run;
    logic              in_range;
    logic              acc_wr;
    logic              acc_rd;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_valid_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] rd_data_q;

    assign clr_last = ({1'b0, clr_addr_q} == LAST_L);
    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign acc_wr   = req_valid & run & req_we;
    assign acc_rd   = req_valid & run & ~req_we;

    // State register; reset picks the clear sequence or goes straight to run.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
        else      state_q <= state_d;
    end

    // Next state: leave the clear after the last word has been zeroed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_last) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // FSM outputs: ready/init in run, clear writes while clearing.
    always_comb begin
        run    = rst & (state_q == S_RUN);
        clr_we = rst & (state_q == S_CLEAR);
    end

    assign req_ready = run;
    assign init_done = run;

    // Clear address counter, restarting at word 0 on every reset.
    always_ff @(posedge clk) begin
        if (!rst)        clr_addr_q <= '0;
        else if (clr_we) clr_addr_q <= clr_last ? '0 : clr_addr_q + 1'b1;
    end

    // Array write port: clear zeroes, accepted in-range writes merge enabled bytes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (acc_wr && in_range) begin
            mem[req_addr] <= DATA_W'(be_merge(DATA_W_MAX'(mem[req_addr]),
                                              DATA_W_MAX'(req_wdata),
                                              BE_W_MAX'(req_be)));
        end
    end

    // First read stage; data forced to 0 for idle cycles and out-of-range reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= acc_rd;
            rd_err_q   <= acc_rd & ~in_range;
            rd_data_q  <= (acc_rd && in_range) ? mem[req_addr] : '0;
        end
    end

    ram_rd_delay #(
        .DATA_W (DATA_W),
        .STAGES (STAGES)
    ) u_rd_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid_q),
        .in_data   (rd_data_q),
        .in_err    (rd_err_q),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule
